alu_seq: RTL

Parametrised, registered successor to the datapath ALU in the RISC machine. It performs single-cycle add, sub, and, negate, or, xor and move operations, and an optional multi-cycle shift-add multiply, behind a start/ready/done handshake. Result and N/V/Z status are held in registers until the next accepted operation. It sits between the register-file read ports (A/B operand path) and the writeback mux, and the controller FSM sequences it.

---
 rtl/alu_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered ALU (add/sub/and/neg/or/xor/mov) behind a
//            start/ready/done handshake, with an optional shift-add multiply
//            enabled by the ALU_SEQ_MUL_EN macro.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] ain,
    input  logic [W-1:0] bin,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] out,
    output logic [2:0]   status
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_NEG = 3'b011;
    localparam logic [2:0] c_OP_OR  = 3'b100;
    localparam logic [2:0] c_OP_XOR = 3'b101;
    localparam logic [2:0] c_OP_MUL = 3'b110;
    localparam logic [2:0] c_OP_MOV = 3'b111;

    logic [W-1:0] r_out;
    logic [2:0]   r_status;
    logic         r_done;

    logic         w_accept;
    logic [W-1:0] w_res;
    logic         w_v;
    logic         w_fin_load;
    logic [W-1:0] w_fin_res;
    logic         w_fin_v;

    assign w_accept = start && ready;

    // Single-cycle result straight from the operand ports at the accept edge.
    // MUL here only matters when the multiplier is absent: zero with V set.
    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_res = ain + bin;
                w_v   = (ain[W-1] == bin[W-1]) && (w_res[W-1] != ain[W-1]);
            end
            c_OP_SUB: begin
                w_res = ain - bin;
                w_v   = (ain[W-1] != bin[W-1]) && (w_res[W-1] != ain[W-1]);
            end
            c_OP_AND: w_res = ain & bin;
            c_OP_NEG: begin
                w_res = ~bin + 1'b1;
                w_v   = (bin == {1'b1, {(W-1){1'b0}}});
            end
            c_OP_OR:  w_res = ain | bin;
            c_OP_XOR: w_res = ain ^ bin;
            c_OP_MUL: begin
                w_res = '0;
                w_v   = 1'b1;
            end
            c_OP_MOV: w_res = bin;
            default: begin
                w_res = '0;
                w_v   = 1'b0;
            end
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(W);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_mplr;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] w_acc_next;
    logic           w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc + (r_mplr[0] ? ({{W{1'b0}}, r_a} << r_cnt) : '0);
        w_last       = (r_state == S_MUL) && (r_cnt == CW'(W - 1));
        case (r_state)
            S_IDLE: if (start && (op == c_OP_MUL)) w_state_next = S_MUL;
            S_MUL:  if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign ready = (r_state == S_IDLE);

    // The multiplier register shifts right so bit i is always at position 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_mplr <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (w_accept && (op == c_OP_MUL)) begin
            r_a    <= ain;
            r_mplr <= bin;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (r_state == S_MUL) begin
            r_acc  <= w_acc_next;
            r_mplr <= r_mplr >> 1;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign w_fin_load = (w_accept && (op != c_OP_MUL)) || w_last;
    assign w_fin_res  = w_last ? w_acc_next[W-1:0] : w_res;
    assign w_fin_v    = w_last ? (|w_acc_next[2*W-1:W]) : w_v;
`else
    assign ready      = 1'b1;
    assign w_fin_load = w_accept;
    assign w_fin_res  = w_res;
    assign w_fin_v    = w_v;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out    <= '0;
            r_status <= 3'b000;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_fin_load;
            if (w_fin_load) begin
                r_out    <= w_fin_res;
                r_status <= {w_fin_res[W-1], w_fin_v, (w_fin_res == '0)};
            end
        end
    end

    assign out    = r_out;
    assign status = r_status;
    assign done   = r_done;

endmodule

`default_nettype wire
